// File: rtl/bus_sched_pkg.sv
// Shared FSM encoding and destination-field constants for the round-robin bus scheduler.
package bus_sched_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        POP  = 2'd1,
        PUSH = 2'd2
    } sched_state_t;

    localparam logic [7:0]  BCAST_DEFAULT = 8'hFF;
    localparam int unsigned DEST_W        = 8;

endpackage

// File: rtl/bus_rr_scheduler_rr_pick.sv
// Combinational round-robin picker: first set request strictly above `last`, else wrap to the lowest.
module rr_pick #(
    parameter int unsigned n = 4
) (
    input  logic [n-1:0] req,
    input  logic [7:0]   last,
    output logic [7:0]   next,
    output logic         valid
);

    logic [7:0] hi_idx;
    logic [7:0] lo_idx;
    logic       hi_valid;

    // Descending scan so the final write in each class is its lowest index.
    always_comb begin
        hi_idx   = '0;
        lo_idx   = '0;
        hi_valid = 1'b0;
        valid    = 1'b0;
        for (int unsigned i = n; i > 0; i--) begin
            if (req[i-1]) begin
                lo_idx = 8'(i - 1);
                valid  = 1'b1;
                if ((i - 1) > 32'(last)) begin
                    hi_idx   = 8'(i - 1);
                    hi_valid = 1'b1;
                end
            end
        end
        next = hi_valid ? hi_idx : lo_idx;
    end

endmodule

// File: rtl/bus_rr_scheduler.sv
// Round-robin bus scheduler: picks a pending port, pops its head packet and
// forwards it to the addressed port(s), counting undeliverable packets.
module bus_rr_scheduler
    import bus_sched_pkg::*;
#(
    parameter int unsigned bits      = 1,
    parameter int unsigned drvrs     = 4,
    parameter int unsigned pckg_sz   = 16,
    parameter logic [7:0]  broadcast = BCAST_DEFAULT
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic [drvrs-1:0]                pndng,
    input  logic [drvrs-1:0][pckg_sz-1:0]   D_pop,
    output logic [drvrs-1:0]                pop,
    output logic [drvrs-1:0]                push,
    output logic [pckg_sz-1:0]              D_push,
    output logic [7:0]                      grant_id,
    output logic                            busy,
    output logic [15:0]                     drop_cnt
);

    // Only a single lane is implemented; any other setting keeps the bus parked.
    localparam logic LANE_OK = (bits == 1);

    sched_state_t       state;
    logic [7:0]         last_grant;
    logic [7:0]         pick_idx;
    logic               pick_valid;
    logic               gnt_pend;
    logic [pckg_sz-1:0] gnt_pkt;
    logic [DEST_W-1:0]  dest;
    logic               is_uni;
    logic               drop_now;
    logic [drvrs-1:0]   push_map;
    logic [15:0]        drop_q;

    rr_pick #(.n(drvrs)) u_pick (
        .req   (pndng),
        .last  (last_grant),
        .next  (pick_idx),
        .valid (pick_valid)
    );

    always_comb begin
        gnt_pend = 1'b0;
        gnt_pkt  = '0;
        for (int unsigned i = 0; i < drvrs; i++) begin
            if (grant_id == 8'(i)) begin
                gnt_pend = pndng[i];
                gnt_pkt  = D_pop[i];
            end
        end
    end

    // Destination decode works on the latched packet so it is stable during PUSH.
    assign dest   = D_push[pckg_sz-1 -: DEST_W];
    assign is_uni = (32'(dest) < drvrs);

    always_comb begin
        push_map = '0;
        drop_now = 1'b0;
        if (is_uni) begin
            for (int unsigned i = 0; i < drvrs; i++) begin
                push_map[i] = (dest == 8'(i));
            end
        end else if (dest == broadcast) begin
            for (int unsigned i = 0; i < drvrs; i++) begin
                push_map[i] = (grant_id != 8'(i));
            end
        end else begin
            drop_now = 1'b1;
        end
    end

    always_comb begin
        pop = '0;
        if (state == POP && gnt_pend) begin
            for (int unsigned i = 0; i < drvrs; i++) begin
                pop[i] = (grant_id == 8'(i));
            end
        end
    end

    assign push     = (state == PUSH) ? push_map : '0;
    assign busy     = (state != IDLE);
    assign drop_cnt = drop_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            grant_id   <= '0;
            last_grant <= 8'(drvrs - 1);
            D_push     <= '0;
            drop_q     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (pick_valid && LANE_OK) begin
                        grant_id <= pick_idx;
                        state    <= POP;
                    end
                end
                POP: begin
                    if (gnt_pend) begin
                        D_push     <= gnt_pkt;
                        last_grant <= grant_id;
                        state      <= PUSH;
                    end else begin
                        state <= IDLE;
                    end
                end
                PUSH: begin
                    if (drop_now && drop_q != '1) begin
                        drop_q <= drop_q + 16'd1;
                    end
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_bus_rr_scheduler.sv
// Scoreboard bench for bus_rr_scheduler (4 ports, 16-bit packets).
module tb_bus_rr_scheduler;

    logic             clk = 1'b0;
    logic             reset;
    logic [3:0]       pndng;
    logic [3:0][15:0] D_pop;
    logic [3:0]       pop;
    logic [3:0]       push;
    logic [15:0]      D_push;
    logic [7:0]       grant_id;
    logic             busy;
    logic [15:0]      drop_cnt;

    always #5 clk = ~clk;

    bus_rr_scheduler #(
        .bits      (1),
        .drvrs     (4),
        .pckg_sz   (16),
        .broadcast (8'hFF)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .pndng    (pndng),
        .D_pop    (D_pop),
        .pop      (pop),
        .push     (push),
        .D_push   (D_push),
        .grant_id (grant_id),
        .busy     (busy),
        .drop_cnt (drop_cnt)
    );

    typedef struct {
        logic [3:0]  pop;
        logic [3:0]  push;
        logic [15:0] data;
        logic [7:0]  gid;
    } exp_t;

    // Head packet of each port and the delivery pattern it must produce.
    logic [15:0] port_data [4] = '{16'h02AB, 16'hFF55, 16'h0711, 16'h0030};
    logic [3:0]  port_push [4] = '{4'b0100, 4'b1101, 4'b0000, 4'b0001};

    exp_t sb[$];
    exp_t cur;
    int   vectors     = 0;
    int   miscompares = 0;
    int   cnt [4]     = '{0, 0, 0, 0};
    bit   auto_drv    = 1'b0;
    bit   mon_en      = 1'b0;
    bit   in_push     = 1'b0;
    bit   gap_chk     = 1'b0;
    int   last_pop_cyc = -1;
    int   cyc         = 0;
    logic [3:0] pop_q = '0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic exp_t mk(input int g);
        exp_t e;
        e.pop  = 4'(1 << g);
        e.push = port_push[g];
        e.data = port_data[g];
        e.gid  = 8'(g);
        return e;
    endfunction

    // Per-port FIFO model: pndng follows remaining packet counts, consumed on pop.
    initial forever begin
        @(posedge clk);
        #1;
        if (auto_drv) begin
            for (int i = 0; i < 4; i++) begin
                if (pop_q[i] && cnt[i] > 0) cnt[i]--;
            end
            for (int i = 0; i < 4; i++) pndng[i] = (cnt[i] > 0);
        end
    end

    initial forever begin
        @(negedge clk);
        cyc++;
        pop_q = pop;
        if (mon_en && reset) begin
            if (in_push) begin
                check_val("push_vec", 32'(push), 32'(cur.push));
                check_val("d_push", 32'(D_push), 32'(cur.data));
                check_val("pop_during_push", 32'(pop), 32'd0);
                check_val("busy_push", 32'(busy), 32'd1);
                in_push = 1'b0;
            end else if (pop != 4'd0) begin
                if (sb.size() == 0) begin
                    check_val("unexpected_pop", 32'(pop), 32'd0);
                end else begin
                    cur = sb.pop_front();
                    check_val("pop_vec", 32'(pop), 32'(cur.pop));
                    check_val("grant_id", 32'(grant_id), 32'(cur.gid));
                    check_val("push_during_pop", 32'(push), 32'd0);
                    if (gap_chk && last_pop_cyc >= 0)
                        check_val("pop_gap", 32'(cyc - last_pop_cyc), 32'd3);
                    last_pop_cyc = cyc;
                    in_push = 1'b1;
                end
            end else if (push != 4'd0) begin
                check_val("stray_push", 32'(push), 32'd0);
            end
        end
    end

    task automatic drain(input string tag);
        int n = 0;
        while ((sb.size() != 0 || in_push) && n < 300) begin
            @(negedge clk);
            #2;
            n++;
        end
        check_val({tag, "_drain_timeout"}, 32'(n >= 300), 32'd0);
        if (n >= 300) begin
            sb.delete();
            in_push = 1'b0;
        end
        repeat (6) begin
            @(negedge clk);
            #2;
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        #2;
        mon_en   = 1'b0;
        auto_drv = 1'b0;
        pndng    = '0;
        for (int i = 0; i < 4; i++) cnt[i] = 0;
        reset = 1'b0;
        @(negedge clk);
        #2;
        reset   = 1'b1;
        in_push = 1'b0;
        mon_en  = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int n;
        reset = 1'b0;
        pndng = '0;
        for (int i = 0; i < 4; i++) D_pop[i] = port_data[i];
        repeat (2) @(negedge clk);
        #2;
        check_val("rst_pop", 32'(pop), 32'd0);
        check_val("rst_push", 32'(push), 32'd0);
        check_val("rst_d_push", 32'(D_push), 32'd0);
        check_val("rst_grant", 32'(grant_id), 32'd0);
        check_val("rst_busy", 32'(busy), 32'd0);
        check_val("rst_drop", 32'(drop_cnt), 32'd0);
        reset  = 1'b1;
        mon_en = 1'b1;

        // Single unicast from port 0 to port 2.
        sb.push_back(mk(0));
        cnt[0] = 1;
        auto_drv = 1'b1;
        drain("single");
        check_val("single_drop", 32'(drop_cnt), 32'd0);

        // All ports requesting: strict rotation starting at port 0, 3-cycle spacing.
        do_reset();
        gap_chk = 1'b1;
        last_pop_cyc = -1;
        for (int r = 0; r < 2; r++)
            for (int g = 0; g < 4; g++) sb.push_back(mk(g));
        for (int i = 0; i < 4; i++) cnt[i] = 2;
        auto_drv = 1'b1;
        drain("rotation");
        gap_chk = 1'b0;
        check_val("rotation_drop", 32'(drop_cnt), 32'd2);

        // Counter saturation from a preloaded near-full value.
        dut.drop_q = 16'hFFFE;
        sb.push_back(mk(2));
        cnt[2] = 1;
        drain("sat1");
        check_val("drop_to_max", 32'(drop_cnt), 32'hFFFF);
        sb.push_back(mk(2));
        cnt[2] = 1;
        drain("sat2");
        check_val("drop_saturated", 32'(drop_cnt), 32'hFFFF);

        // Grant withdrawn before POP: no strobes, last_grant stays at port 1.
        do_reset();
        sb.push_back(mk(1));
        cnt[1] = 1;
        auto_drv = 1'b1;
        drain("pre_abort");
        auto_drv = 1'b0;
        @(posedge clk);
        #1;
        pndng = 4'b1000;
        @(posedge clk);
        #1;
        pndng = 4'b0000;
        @(negedge clk);
        #2;
        check_val("abort_busy_pop", 32'(busy), 32'd1);
        check_val("abort_grant", 32'(grant_id), 32'd3);
        check_val("abort_no_pop", 32'(pop), 32'd0);
        @(negedge clk);
        #2;
        check_val("abort_idle", 32'(busy), 32'd0);
        sb.push_back(mk(2));
        sb.push_back(mk(3));
        sb.push_back(mk(0));
        cnt[0] = 1;
        cnt[2] = 1;
        cnt[3] = 1;
        auto_drv = 1'b1;
        drain("post_abort");
        check_val("post_abort_drop", 32'(drop_cnt), 32'd1);

        // Reset landing in the PUSH cycle kills the transfer immediately.
        mon_en   = 1'b0;
        auto_drv = 1'b0;
        @(posedge clk);
        #1;
        pndng = 4'b0010;
        n = 0;
        do begin
            @(negedge clk);
            #2;
            n++;
        end while (pop == 4'd0 && n < 10);
        check_val("rip_pop", 32'(pop), 32'b0010);
        @(posedge clk);
        #1;
        pndng = 4'b0000;
        @(negedge clk);
        #2;
        check_val("rip_push_pre", 32'(push), 32'b1101);
        check_val("rip_data_pre", 32'(D_push), 32'hFF55);
        reset = 1'b0;
        #1;
        check_val("rip_push", 32'(push), 32'd0);
        check_val("rip_busy", 32'(busy), 32'd0);
        check_val("rip_d_push", 32'(D_push), 32'd0);
        check_val("rip_grant", 32'(grant_id), 32'd0);
        check_val("rip_drop", 32'(drop_cnt), 32'd0);
        @(negedge clk);
        #2;
        reset   = 1'b1;
        in_push = 1'b0;
        mon_en  = 1'b1;
        sb.push_back(mk(0));
        sb.push_back(mk(2));
        cnt[0] = 1;
        cnt[2] = 1;
        auto_drv = 1'b1;
        drain("post_reset");
        check_val("post_reset_drop", 32'(drop_cnt), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/bus_rr_scheduler.md
BUS_RR_SCHEDULER -- requirements
Module: bus_rr_scheduler

Interface
REQ-001 The block SHALL have parameter bits, default 1, giving the number of bus lanes; only value 1 is supported.
REQ-002 The block SHALL have parameter drvrs, default 4, giving the number of attached driver/monitor ports (2..16).
REQ-003 The block SHALL have parameter pckg_sz, default 16, giving the packet width in bits (>= 9).
REQ-004 The block SHALL have parameter broadcast, default 8'hFF, giving the destination ID that addresses all ports.
REQ-005 The block SHALL have port clk, input, 1 bit: single clock, all state updates on its rising edge.
REQ-006 The block SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-007 The block SHALL have port pndng, input, [drvrs-1:0]: per-port "packet waiting" flag.
REQ-008 The block SHALL have port D_pop, input, [drvrs-1:0][pckg_sz-1:0]: per-port head-of-queue packet.
REQ-009 The block SHALL have port pop, output, [drvrs-1:0]: one-hot, one-cycle dequeue strobe.
REQ-010 The block SHALL have port push, output, [drvrs-1:0]: per-port enqueue strobe.
REQ-011 The block SHALL have port D_push, output, [pckg_sz-1:0]: packet driven to all ports.
REQ-012 The block SHALL have port grant_id, output, [7:0]: index of the port currently owning the bus.
REQ-013 The block SHALL have port busy, output, 1 bit: high while the FSM is not in IDLE.
REQ-014 The block SHALL have port drop_cnt, output, [15:0]: saturating count of dropped packets.

Function
REQ-015 The packet destination SHALL be D_pop[g][pckg_sz-1 -: 8].
REQ-016 The FSM SHALL have exactly three states: IDLE, POP and PUSH.
REQ-017 In IDLE with pndng != 0, the block SHALL select g = the first set pndng bit searching upward, with wrap, from last_grant+1; it SHALL register g into grant_id and go to POP.
REQ-018 In IDLE with pndng == 0, the FSM SHALL stay in IDLE and all strobes SHALL stay low.
REQ-019 In POP, if pndng[g] is 1, the block SHALL assert pop[g] for exactly one cycle, latch D_pop[g], set last_grant = g and go to PUSH.
REQ-020 In POP, if pndng[g] is 0, the block SHALL issue no pop, leave last_grant unchanged and return to IDLE.
REQ-021 In PUSH, D_push SHALL equal the latched packet for exactly one cycle.
REQ-022 In PUSH with dest < drvrs, the block SHALL drive push = one-hot(dest); self-addressed delivery is allowed.
REQ-023 In PUSH with dest == broadcast, the block SHALL drive push = all ones except bit g.
REQ-024 In PUSH with any other dest, the block SHALL drive push = 0 and increment drop_cnt, saturating at 16'hFFFF.
REQ-025 From PUSH the FSM SHALL always go to IDLE.
REQ-026 Minimum packet spacing SHALL be 3 cycles; pop-to-push latency SHALL be 1 cycle.
REQ-027 pop and push SHALL never be asserted in the same cycle.
REQ-028 A port requesting continuously SHALL wait at most drvrs-1 other grants before being served.
REQ-029 D_push SHALL hold its last value outside PUSH.
REQ-030 busy SHALL be high in POP and PUSH only.

Reset
REQ-031 While reset is 0, the FSM SHALL be in IDLE and pop, push, D_push, grant_id, busy and drop_cnt SHALL all be 0, asynchronously.
REQ-032 On reset, last_grant SHALL be set to drvrs-1, so the first grant goes to port 0.
REQ-033 A reset asserted in POP or PUSH SHALL abort the transfer with no further strobes; the packet is not re-sent.

Structure
REQ-034 Package bus_sched_pkg SHALL hold the FSM state enum, the BCAST_DEFAULT constant (8'hFF) and the dest-field width constant (8).
REQ-035 Sub-module rr_pick SHALL be purely combinational (req vector, last index -> next index, valid) and shall be the only sub-module.

Verification (drvrs=4, pckg_sz=16)
REQ-036 Reset, then pndng=4'b0001 with D_pop[0]=16'h02AB -> pop[0] one cycle, next cycle push=4'b0100 and D_push=16'h02AB.
REQ-037 pndng=4'b1111 held continuously -> grant order 0,1,2,3,0 with pops 3 cycles apart.
REQ-038 Port 1 sends 16'hFF55 -> push=4'b1101 and D_push=16'hFF55 for one cycle.
REQ-039 Port 2 sends 16'h0711 -> no push, drop_cnt 0 -> 1; preload 16'hFFFF -> drop_cnt stays 16'hFFFF.
REQ-040 Grant to port 3, then pndng[3] drops before POP -> no pop/push, return to IDLE; next grant honours last_grant.
REQ-041 reset=0 asserted in the PUSH cycle -> push=0 immediately, busy=0, next grant goes to port 0.
